// File: rtl/pe_fmap_feeder.sv
// Feature-map feeder: reads a block of words from the feature buffer
// and streams them to the PE through a 2-entry skid buffer.
module pe_fmap_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic                  full_column,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  pe_start_load,
  output logic                  pe_load_full_column,
  output logic [DATA_WIDTH-1:0] pe_data,
  output logic                  pe_data_en,
  input  logic                  pe_fifo_full,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    ANNOUNCE,
    STREAM
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  state_t state, next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] issued_q;
  logic [ADDR_WIDTH-1:0] sent_q;
  logic                  fc_q;
  logic                  done_q;
  logic                  pend_q;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  wp_q;
  logic                  rp_q;
  logic [1:0]            cnt_q;

  logic       accept;
  logic       zero_start;
  logic       rd_en;
  logic       pop;
  logic       last_pop;
  logic       empty;
  logic [2:0] level;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next       = state;
    accept     = 1'b0;
    zero_start = 1'b0;
    rd_en      = 1'b0;
    empty      = (cnt_q == 2'd0);
    pop        = !empty && !pe_fifo_full && !rst;
    last_pop   = pop && (state == STREAM)
                 && (sent_q == len_q - ONE);
    // words held plus words still in flight from the buffer
    level      = {1'b0, cnt_q} + {2'b00, pend_q};
    unique case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            accept = 1'b1;
            next   = ANNOUNCE;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      ANNOUNCE: begin
        rd_en = 1'b1;
        next  = STREAM;
      end
      STREAM: begin
        rd_en = (issued_q != len_q)
                && (level < 3'd2 + {2'b00, pop});
        if (last_pop) next = IDLE;
      end
      default: next = IDLE;
    endcase
    if (rst) begin
      accept     = 1'b0;
      zero_start = 1'b0;
      rd_en      = 1'b0;
      next       = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      sent_q   <= '0;
      fc_q     <= 1'b0;
      done_q   <= 1'b0;
      pend_q   <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      done_q <= zero_start | last_pop;
      pend_q <= rd_en;
      if (accept) begin
        addr_q   <= base_addr;
        len_q    <= length;
        fc_q     <= full_column;
        issued_q <= '0;
        sent_q   <= '0;
      end else begin
        if (rd_en) begin
          addr_q   <= addr_q + ONE;
          issued_q <= issued_q + ONE;
        end
        if (pop) sent_q <= sent_q + ONE;
      end
      if (pend_q) begin
        buf_q[wp_q] <= mem_rd_data;
        wp_q        <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      unique case ({pend_q, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign mem_rd_en           = rd_en;
  assign mem_rd_addr         = rst ? '0 : addr_q;
  assign pe_start_load       = (state == ANNOUNCE) && !rst;
  assign pe_load_full_column = fc_q && !rst;
  assign pe_data_en          = pop;
  assign pe_data             = (rst || empty) ? '0 : buf_q[rp_q];
  assign busy                = (state != IDLE) && !rst;
  assign done                = done_q && !rst;

endmodule

// File: tb/tb_pe_fmap_feeder.sv
// Directed bench for pe_fmap_feeder: buffer model returns 0xA000|addr,
// a negedge monitor logs reads, transfers and buffer occupancy.
module tb_pe_fmap_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [7:0]  length = '0;
  logic        full_column = 1'b0;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_addr;
  logic [15:0] mem_rd_data = 16'hDEAD;
  logic        pe_start_load;
  logic        pe_load_full_column;
  logic [15:0] pe_data;
  logic        pe_data_en;
  logic        pe_fifo_full = 1'b0;
  logic        busy;
  logic        done;

  pe_fmap_feeder #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .base_addr           (base_addr),
    .length              (length),
    .full_column         (full_column),
    .mem_rd_en           (mem_rd_en),
    .mem_rd_addr         (mem_rd_addr),
    .mem_rd_data         (mem_rd_data),
    .pe_start_load       (pe_start_load),
    .pe_load_full_column (pe_load_full_column),
    .pe_data             (pe_data),
    .pe_data_en          (pe_data_en),
    .pe_fifo_full        (pe_fifo_full),
    .busy                (busy),
    .done                (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    mem_rd_data <= mem_rd_en ? (16'hA000 | {8'h00, mem_rd_addr})
                             : 16'hDEAD;

  int          tests = 0;
  int          fails = 0;
  int          rdc[$];
  logic [7:0]  rda[$];
  int          xfc[$];
  logic [15:0] xfd[$];
  int          slc[$];
  int          occ_rd = 0;
  int          occ_lag = 0;
  int          occ_xf = 0;
  int          occ_max = 0;
  int          fc_bad = 0;
  logic        exp_fc = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      occ_rd  = 0;
      occ_lag = 0;
      occ_xf  = 0;
    end else begin
      if (occ_lag - occ_xf > occ_max) occ_max = occ_lag - occ_xf;
      occ_lag = occ_rd;
      occ_rd += int'(mem_rd_en);
      occ_xf += int'(pe_data_en);
      if (mem_rd_en) begin
        rdc.push_back(cyc);
        rda.push_back(mem_rd_addr);
      end
      if (pe_data_en) begin
        xfc.push_back(cyc);
        xfd.push_back(pe_data);
      end
      if (pe_start_load) slc.push_back(cyc);
      if (busy && pe_load_full_column !== exp_fc) fc_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] b, input logic [7:0] l,
                        input logic f, output int s);
    rdc.delete(); rda.delete();
    xfc.delete(); xfd.delete();
    slc.delete();
    fc_bad      = 0;
    start       = 1'b1;
    base_addr   = b;
    length      = l;
    full_column = f;
    if (l != 8'd0) exp_fc = f;
    s = cyc;
  endtask

  task automatic wait_done(input int budget, input int s,
                           input int flo, input int fhi,
                           input int st2, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      start = (st2 >= 0) && (cyc - s == st2);
      if (start) begin
        base_addr   = 8'h99;
        length      = 8'd7;
        full_column = ~exp_fc;
      end
      pe_fifo_full = (cyc - s >= flo) && (cyc - s <= fhi);
      got = done;
    end
    start        = 1'b0;
    pe_fifo_full = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    bit got;
    int nd;

    // reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_rd_addr", mem_rd_addr, 0);
    chk("rst_start_load", pe_start_load, 0);
    chk("rst_fc", pe_load_full_column, 0);
    chk("rst_data_en", pe_data_en, 0);
    chk("rst_data", pe_data, 0);
    rst = 1'b0;
    tick();

    // basic 3-word job
    launch(8'h10, 8'd3, 1'b1, s);
    wait_done(40, s, -1, -1, -1, got);
    chk("j1_got_done", got, 1);
    chk("j1_done_cyc", cyc - s, 6);
    chk("j1_busy_in_done", busy, 0);
    chk("j1_fc_held", pe_load_full_column, 1);
    chk("j1_fc_bad", fc_bad, 0);
    chk("j1_sl_n", slc.size(), 1);
    if (slc.size() > 0) chk("j1_sl_cyc", slc[0] - s, 1);
    chk("j1_rd_n", rdc.size(), 3);
    chk("j1_xf_n", xfc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < rdc.size()) begin
        chk("j1_rd_cyc", rdc[i] - s, 1 + i);
        chk("j1_rd_addr", rda[i], 8'h10 + i);
      end
      if (i < xfc.size()) begin
        chk("j1_xf_cyc", xfc[i] - s, 3 + i);
        chk("j1_xf_data", xfd[i], 16'hA010 + i);
      end
    end
    tick();

    // 6-word job, PE full cycles 4-8, extra start at cycle 5
    occ_max = 0;
    launch(8'h20, 8'd6, 1'b0, s);
    wait_done(60, s, 4, 8, 5, got);
    chk("j2_got_done", got, 1);
    chk("j2_done_cyc", cyc - s, 14);
    chk("j2_xf_n", xfc.size(), 6);
    chk("j2_rd_n", rdc.size(), 6);
    chk("j2_fc_bad", fc_bad, 0);
    chk("j2_occ_le2", occ_max <= 2, 1);
    if (xfc.size() == 6) begin
      chk("j2_first_xf", xfc[0] - s, 3);
      chk("j2_resume_xf", xfc[1] - s, 9);
      chk("j2_last_xf", xfc[5] - s, 13);
    end
    for (int i = 0; i < 6; i++)
      if (i < xfd.size())
        chk("j2_xf_data", xfd[i], 16'hA020 + i);
    tick();

    // address wrap
    launch(8'hFE, 8'd4, 1'b0, s);
    wait_done(40, s, -1, -1, -1, got);
    chk("j3_got_done", got, 1);
    chk("j3_done_cyc", cyc - s, 7);
    chk("j3_rd_n", rdc.size(), 4);
    if (rdc.size() == 4) begin
      chk("j3_rd0", rda[0], 8'hFE);
      chk("j3_rd1", rda[1], 8'hFF);
      chk("j3_rd2", rda[2], 8'h00);
      chk("j3_rd3", rda[3], 8'h01);
    end
    if (xfd.size() == 4) begin
      chk("j3_xf1", xfd[1], 16'hA0FF);
      chk("j3_xf2", xfd[2], 16'hA000);
    end
    tick();

    // zero length
    launch(8'h30, 8'd0, 1'b1, s);
    wait_done(10, s, -1, -1, -1, got);
    chk("j4_got_done", got, 1);
    chk("j4_done_cyc", cyc - s, 1);
    chk("j4_busy", busy, 0);
    tick();
    chk("j4_no_sl", slc.size(), 0);
    chk("j4_no_rd", rdc.size(), 0);
    chk("j4_fc_kept", pe_load_full_column, 0);

    // reset after 2nd transfer of a 5-word job
    launch(8'h40, 8'd5, 1'b1, s);
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("j5_xf2_en", pe_data_en, 1);
    chk("j5_xf2_data", pe_data, 16'hA041);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("j5_busy0", busy, 0);
    chk("j5_done0", done, 0);
    chk("j5_rd_en0", mem_rd_en, 0);
    chk("j5_data_en0", pe_data_en, 0);
    chk("j5_data0", pe_data, 0);
    chk("j5_sl0", pe_start_load, 0);
    chk("j5_fc0", pe_load_full_column, 0);
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      nd += int'(done);
    end
    chk("j5_no_done", nd, 0);
    chk("j5_xf_n", xfc.size(), 2);

    // restart after abort, then start in the done cycle
    launch(8'h50, 8'd2, 1'b0, s);
    wait_done(40, s, -1, -1, -1, got);
    chk("j6_got_done", got, 1);
    chk("j6_done_cyc", cyc - s, 5);
    chk("j6_xf_n", xfc.size(), 2);
    if (xfd.size() == 2) begin
      chk("j6_xf0", xfd[0], 16'hA050);
      chk("j6_xf1", xfd[1], 16'hA051);
    end
    launch(8'h60, 8'd1, 1'b1, s);
    wait_done(40, s, -1, -1, -1, got);
    chk("j7_got_done", got, 1);
    chk("j7_done_cyc", cyc - s, 4);
    chk("j7_sl_n", slc.size(), 1);
    chk("j7_xf_n", xfc.size(), 1);
    if (xfd.size() == 1) chk("j7_xf0", xfd[0], 16'hA060);
    chk("j7_fc", pe_load_full_column, 1);
    chk("occ_max_le2", occ_max <= 2, 1);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pe_fmap_feeder.md
PE_FMAP_FEEDER -- requirements
Module: pe_fmap_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of every streamed word.
REQ-002 Parameter ADDR_WIDTH, default 8, width of the buffer read address and the length field.
REQ-003 Port clk, input, 1, the single clock; every register is updated on its rising edge.
REQ-004 Port rst, input, 1, reset; it is synchronous and active-high.
REQ-005 Port start, input, 1, one-cycle request to begin a transfer.
REQ-006 Port base_addr, input, ADDR_WIDTH, first buffer address; sampled with start.
REQ-007 Port length, input, ADDR_WIDTH, number of words to send; sampled with start.
REQ-008 Port full_column, input, 1, load-mode flag; sampled with start.
REQ-009 Port mem_rd_en, output, 1, read strobe to the feature buffer.
REQ-010 Port mem_rd_addr, output, ADDR_WIDTH, read address to the feature buffer.
REQ-011 Port mem_rd_data, input, DATA_WIDTH, buffer read data; valid exactly one cycle after mem_rd_en.
REQ-012 Port pe_start_load, output, 1, one-cycle start_feature_load pulse to the PE.
REQ-013 Port pe_load_full_column, output, 1, the load_full_cloumn level driven to the PE.
REQ-014 Port pe_data, output, DATA_WIDTH, feature_in word to the PE.
REQ-015 Port pe_data_en, output, 1, feature_in_en to the PE; a word transfers in every cycle it is high.
REQ-016 Port pe_fifo_full, input, 1, fifo_full_fmap from the PE.
REQ-017 Port busy, output, 1, transfer in progress.
REQ-018 Port done, output, 1, one-cycle completion pulse.

Function
REQ-019 The FSM SHALL have three states: IDLE, ANNOUNCE and STREAM.
REQ-020 In IDLE, start with length!=0 SHALL latch base_addr, length and full_column, and move the FSM to ANNOUNCE.
REQ-021 In IDLE, start with length==0 SHALL leave the FSM in IDLE and pulse done on the next cycle, with no pe_start_load and no reads.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 ANNOUNCE SHALL last exactly one cycle, drive pe_start_load=1, and issue the first read at base_addr.
REQ-024 The FSM SHALL go from ANNOUNCE to STREAM unconditionally.
REQ-025 pe_load_full_column SHALL take the latched full_column from the ANNOUNCE cycle onward and hold it until the next accepted start.
REQ-026 Reads SHALL be issued in ascending address order, base_addr to base_addr+length-1.
REQ-027 Read addresses SHALL wrap modulo 2^ADDR_WIDTH.
REQ-028 Returned words SHALL be captured into a 2-entry FIFO skid buffer.
REQ-029 A read SHALL be issued in a cycle only if (buffer occupancy + reads in flight - pop this cycle) < 2 and reads issued < length.
REQ-030 The skid buffer SHALL never overflow and SHALL never drop a word.
REQ-031 pe_data_en SHALL equal (buffer not empty) AND NOT pe_fifo_full; this is a combinational path from pe_fifo_full.
REQ-032 pe_data SHALL be the buffer head word whenever pe_data_en=1.
REQ-033 With pe_fifo_full held low, the first word SHALL transfer 2 cycles after the ANNOUNCE cycle, and later words SHALL transfer on consecutive cycles, giving 1 word/cycle.
REQ-034 When pe_fifo_full is asserted, transfers SHALL stall with no loss, duplication or reordering.
REQ-035 busy SHALL be 1 from the ANNOUNCE cycle through the cycle of the final transfer.
REQ-036 In the cycle after the final transfer: done=1 for that one cycle, busy=0, and the FSM is in IDLE.
REQ-037 A start in the done cycle SHALL be accepted.

Reset
REQ-038 While rst=1 at a clock edge, the FSM SHALL go to IDLE and the buffer and all counters SHALL clear.
REQ-039 While rst=1 at a clock edge, busy, done, mem_rd_en, pe_start_load, pe_data_en and pe_load_full_column SHALL be 0, and mem_rd_addr and pe_data SHALL be 0.
REQ-040 A rst asserted mid-transfer SHALL abort the transfer without a done pulse; any read data returning in the following cycle SHALL be discarded.

Verification
REQ-041 start (cycle 0), base=0x10, length=3, full_column=1, pe_fifo_full=0 -> pe_start_load at cycle 1; mem_rd_addr 0x10/0x11/0x12 at cycles 1/2/3; words from 0x10/0x11/0x12 transfer at cycles 3/4/5; done at cycle 6; pe_load_full_column=1 throughout.
REQ-042 length=6 with pe_fifo_full high for cycles 4-8 -> exactly 6 transfers in address order, no word lost or duplicated, skid buffer occupancy never exceeds 2, done one cycle after the 6th transfer.
REQ-043 base=0xFE, length=4 -> read addresses 0xFE, 0xFF, 0x00, 0x01.
REQ-044 length=0 -> done pulse one cycle after start, no pe_start_load, no mem_rd_en; a second start during a busy transfer -> ignored, latched parameters unchanged.
REQ-045 rst asserted after the 2nd transfer of a length-5 job -> all outputs 0 next cycle, no done pulse; a new start with length=2 then completes normally.
